// File: rtl/ball_vertical_bounce.sv
// Single-axis bouncing ball: counts visible lines, moves once per frame and reflects off the walls.
// Optional macro BALL_ACCEL_EN: each wall bounce raises the speed by one (saturating).
module ball_vertical_bounce #(
    parameter int P_HEIGHT     = 480,
    parameter int P_BALL_SIZE  = 8,
    parameter int P_SPEED_BITS = 3,
    parameter int P_INIT_SPEED = 2
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_n,
    input  logic                          i_HReset,
    input  logic                          i_VBlank,
    input  logic                          i_Serve,
    input  logic                          i_ServeDir,
    input  logic [P_SPEED_BITS-1:0]       i_Speed,
    output logic                          o_Video,
    output logic [$clog2(P_HEIGHT)-1:0]   o_Y,
    output logic                          o_Dir,
    output logic                          o_Bounce
);

    // state    | meaning
    // DIR_UP   | ball moving towards line 0
    // DIR_DOWN | ball moving towards the bottom wall
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int H = $clog2(P_HEIGHT);
    localparam logic [H:0]              Y_MAX     = (H+1)'(P_HEIGHT - P_BALL_SIZE);
    localparam logic [H-1:0]            Y_CENTRE  = H'((P_HEIGHT - P_BALL_SIZE) / 2);
    localparam logic [H-1:0]            LINE_LAST = H'(P_HEIGHT - 1);
    localparam logic [H:0]              BALL_H    = (H+1)'(P_BALL_SIZE);
    localparam logic [P_SPEED_BITS-1:0] SPD_INIT  = P_SPEED_BITS'(P_INIT_SPEED);

    logic [H-1:0]            line_q, line_d;
    logic [H-1:0]            y_q, y_d;
    dir_t                    dir_q, dir_d;
    logic [P_SPEED_BITS-1:0] spd_q, spd_d;
    logic                    vblank_q;
    logic                    tick_q;
    logic                    bounce_q, bounce_d;

    logic [H:0] y_ext, spd_ext, sum_ext, line_ext;
    logic       hit_bottom, hit_top;

    assign y_ext      = {1'b0, y_q};
    assign spd_ext    = (H+1)'(spd_q);
    assign sum_ext    = y_ext + spd_ext;
    assign line_ext   = {1'b0, line_q};
    assign hit_bottom = (sum_ext >= Y_MAX);
    assign hit_top    = (y_ext <= spd_ext);

    assign o_Video  = !i_VBlank && (line_ext >= y_ext) && (line_ext < y_ext + BALL_H);
    assign o_Y      = y_q;
    assign o_Dir    = dir_q;
    assign o_Bounce = bounce_q;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            line_q   <= '0;
            y_q      <= Y_CENTRE;
            dir_q    <= DIR_DOWN;
            spd_q    <= SPD_INIT;
            vblank_q <= 1'b0;
            tick_q   <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            line_q   <= line_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            spd_q    <= spd_d;
            vblank_q <= i_VBlank;
            tick_q   <= i_VBlank && !vblank_q;
            bounce_q <= bounce_d;
        end
    end

    always_comb begin
        line_d = line_q;
        if (i_VBlank) begin
            line_d = '0;
        end else if (i_HReset && (line_q != LINE_LAST)) begin
            line_d = line_q + H'(1);
        end
    end

    // Serve outranks the frame tick; a zero speed never moves or reflects the ball.
    always_comb begin
        y_d      = y_q;
        dir_d    = dir_q;
        spd_d    = spd_q;
        bounce_d = 1'b0;
        if (i_Serve) begin
            y_d   = Y_CENTRE;
            dir_d = dir_t'(i_ServeDir);
            spd_d = i_Speed;
        end else if (tick_q && (spd_q != '0)) begin
            if (dir_q == DIR_DOWN) begin
                if (hit_bottom) begin
                    y_d      = Y_MAX[H-1:0];
                    dir_d    = DIR_UP;
                    bounce_d = 1'b1;
                end else begin
                    y_d = sum_ext[H-1:0];
                end
            end else begin
                if (hit_top) begin
                    y_d      = '0;
                    dir_d    = DIR_DOWN;
                    bounce_d = 1'b1;
                end else begin
                    y_d = y_q - spd_q;
                end
            end
`ifdef BALL_ACCEL_EN
            if (bounce_d && (spd_q != '1)) begin
                spd_d = spd_q + P_SPEED_BITS'(1);
            end
`else
`endif
        end
    end

endmodule

// File: tb/tb_ball_vertical_bounce.sv
// Directed bench for ball_vertical_bounce: video-window table plus frame-by-frame motion sequences.
module tb_ball_vertical_bounce;

    localparam int HEIGHT = 480;
    localparam int BALL   = 8;
    localparam int CENTRE = 236;
    localparam int YMAX   = 472;
    localparam int SPDMAX = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hreset;
    logic       vblank;
    logic       serve;
    logic       serve_dir;
    logic [2:0] speed;
    logic       video;
    logic [8:0] y;
    logic       dir;
    logic       bounce;

    int n_chk  = 0;
    int n_fail = 0;

    int m_y, m_dir, m_spd, m_bounce;
    int cur_line;

    typedef struct {
        bit vb;
        int line;
        bit exp_video;
    } vec_t;

    vec_t vecs[9];

    ball_vertical_bounce dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_HReset  (hreset),
        .i_VBlank  (vblank),
        .i_Serve   (serve),
        .i_ServeDir(serve_dir),
        .i_Speed   (speed),
        .o_Video   (video),
        .o_Y       (y),
        .o_Dir     (dir),
        .o_Bounce  (bounce)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_frame();
        m_bounce = 0;
        if (m_spd != 0) begin
            if (m_dir == 1) begin
                if (m_y + m_spd >= YMAX) begin
                    m_y = YMAX; m_dir = 0; m_bounce = 1;
                end else begin
                    m_y = m_y + m_spd;
                end
            end else begin
                if (m_y <= m_spd) begin
                    m_y = 0; m_dir = 1; m_bounce = 1;
                end else begin
                    m_y = m_y - m_spd;
                end
            end
`ifdef BALL_ACCEL_EN
            if (m_bounce == 1 && m_spd < SPDMAX) m_spd = m_spd + 1;
`endif
        end
    endtask

    // One blanking interval followed by a short visible area; counts bounce cycles seen.
    task automatic frame(input string tag);
        int bc;
        bc = 0;
        @(negedge clk) vblank = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bounce) bc++;
        end
        vblank = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bounce) bc++;
        end
        model_frame();
        chk({tag, " y"}, int'(y), m_y);
        chk({tag, " dir"}, int'(dir), m_dir);
        chk({tag, " bounce_cycles"}, bc, m_bounce);
    endtask

    task automatic do_serve(input bit d, input int s);
        @(negedge clk);
        serve = 1'b1; serve_dir = d; speed = 3'(s);
        @(negedge clk);
        serve = 1'b0;
        m_y = CENTRE; m_dir = d; m_spd = s;
        chk("serve y", int'(y), CENTRE);
        chk("serve dir", int'(dir), int'(d));
        chk("serve bounce", int'(bounce), 0);
    endtask

    task automatic run_until_bounces(input string tag, input int n_b, input int extra);
        int seen;
        int k;
        seen = 0;
        k = 0;
        while (seen < n_b && k < 300) begin
            frame(tag);
            if (m_bounce == 1) seen++;
            k++;
        end
        chk({tag, " bounces reached"}, seen, n_b);
        repeat (extra) frame(tag);
    endtask

    initial begin
        rst_n = 1'b0; hreset = 1'b0; vblank = 1'b0;
        serve = 1'b0; serve_dir = 1'b0; speed = 3'd0;
        m_y = CENTRE; m_dir = 1; m_spd = 2;
        repeat (3) @(negedge clk);
        chk("reset y", int'(y), CENTRE);
        chk("reset dir", int'(dir), 1);
        chk("reset bounce", int'(bounce), 0);
        rst_n = 1'b1;

        vecs[0] = '{0, 0,   0};
        vecs[1] = '{0, 235, 0};
        vecs[2] = '{0, 236, 1};
        vecs[3] = '{1, 240, 0};
        vecs[4] = '{0, 240, 1};
        vecs[5] = '{0, 243, 1};
        vecs[6] = '{0, 244, 0};
        vecs[7] = '{0, 479, 0};
        vecs[8] = '{0, 752, 0};
        cur_line = 0;
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].line > cur_line) begin
                @(negedge clk) hreset = 1'b1;
                repeat (vecs[i].line - cur_line) @(negedge clk);
                hreset = 1'b0;
                cur_line = vecs[i].line;
            end
            vblank = vecs[i].vb;
            #1;
            chk($sformatf("video line %0d vb %0d", vecs[i].line, vecs[i].vb),
                int'(video), int'(vecs[i].exp_video));
            vblank = 1'b0;
        end

        frame("init speed");
        @(negedge clk) hreset = 1'b1;
        repeat (20) @(negedge clk);
        hreset = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midframe reset y", int'(y), CENTRE);
        chk("midframe reset dir", int'(dir), 1);
        m_y = CENTRE; m_dir = 1; m_spd = 2;
        @(negedge clk) rst_n = 1'b1;
        frame("after reset");

        do_serve(1'b1, 5);
        frame("spd5 f1");
        chk("spd5 step1", int'(y), 241);
        frame("spd5 f2");
        frame("spd5 f3");
        chk("spd5 step3", int'(y), 251);
        speed = 3'd1;
        frame("speed ignored");
        chk("speed ignored y", int'(y), 256);

        do_serve(1'b0, 4);
        run_until_bounces("spd4 walls", 2, 1);

        do_serve(1'b0, 3);
        run_until_bounces("spd3 top", 1, 1);

        do_serve(1'b1, 0);
        repeat (4) frame("spd0");
        chk("spd0 y", int'(y), CENTRE);

        do_serve(1'b0, 7);
        run_until_bounces("spd7", 2, 2);

        do_serve(1'b0, 5);
        frame("pre coincide");
        @(negedge clk) vblank = 1'b1;
        @(negedge clk) serve = 1'b1; serve_dir = 1'b1; speed = 3'd5;
        @(negedge clk) serve = 1'b0;
        begin
            int bc;
            bc = 0;
            repeat (4) begin
                @(negedge clk);
                if (bounce) bc++;
            end
            vblank = 1'b0;
            chk("coincide bounce", bc, 0);
        end
        chk("coincide y", int'(y), CENTRE);
        chk("coincide dir", int'(dir), 1);
        m_y = CENTRE; m_dir = 1; m_spd = 5;
        frame("post coincide");
        chk("post coincide y", int'(y), 241);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_vertical_bounce.md
BALL_VERTICAL_BOUNCE -- requirements
Module: ball_vertical_bounce

Interface
REQ-001 SHALL have parameter P_HEIGHT, default 480: visible lines per frame.
REQ-002 SHALL have parameter P_BALL_SIZE, default 8: ball height in lines, in the range 1..P_HEIGHT-1.
REQ-003 SHALL have parameter P_SPEED_BITS, default 3: width of the speed value, in lines per frame.
REQ-004 SHALL have parameter P_INIT_SPEED, default 2: speed after reset.
REQ-005 SHALL have port i_Clk, input, 1 bit: the single clock.
REQ-006 SHALL have port i_Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_HReset, input, 1 bit: one-cycle pulse at the end of each line.
REQ-008 SHALL have port i_VBlank, input, 1 bit: high during vertical blanking.
REQ-009 SHALL have port i_Serve, input, 1 bit: one-cycle pulse that recentres the ball.
REQ-010 SHALL have port i_ServeDir, input, 1 bit: direction applied on serve (1 = down).
REQ-011 SHALL have port i_Speed, input, P_SPEED_BITS bits: speed applied on serve.
REQ-012 SHALL have port o_Video, output, 1 bit: high when the current line contains the ball.
REQ-013 SHALL have port o_Y, output, H bits: ball top line, where H = $clog2(P_HEIGHT).
REQ-014 SHALL have port o_Dir, output, 1 bit: current direction (1 = down).
REQ-015 SHALL have port o_Bounce, output, 1 bit: one-cycle pulse on a wall reflection.

Function
REQ-016 Line counter SHALL be held at 0 while i_VBlank=1, SHALL increment on i_HReset while i_VBlank=0, and SHALL saturate at P_HEIGHT-1.
REQ-017 o_Video SHALL be combinational and high iff i_VBlank=0 and o_Y <= line < o_Y+P_BALL_SIZE.
REQ-018 Frame tick SHALL be the internally registered rising edge of i_VBlank, one cycle after the edge; the position SHALL update only on a frame tick, so o_Y is stable across the visible area.
REQ-019 On a frame tick with dir=1: if y+spd >= P_HEIGHT-P_BALL_SIZE then y SHALL become P_HEIGHT-P_BALL_SIZE, dir SHALL become 0 and o_Bounce SHALL pulse; otherwise y SHALL become y+spd.
REQ-020 On a frame tick with dir=0: if y <= spd then y SHALL become 0, dir SHALL become 1 and o_Bounce SHALL pulse; otherwise y SHALL become y-spd.
REQ-021 With spd=0 the ball SHALL not move and SHALL not bounce, even when it sits at a wall.
REQ-022 Arithmetic SHALL use H+1 bits, so y+spd never wraps.
REQ-023 i_Serve SHALL set y to (P_HEIGHT-P_BALL_SIZE)/2 (integer division), dir to i_ServeDir and spd to i_Speed on the next edge, and o_Bounce SHALL stay 0.
REQ-024 When i_Serve coincides with a frame tick, serve SHALL win and no motion SHALL occur that frame.
REQ-025 i_Speed SHALL be sampled only on serve; changes between serves SHALL be ignored.
REQ-026 o_Bounce SHALL be registered and SHALL be high for exactly one cycle, on the cycle after the frame tick.

Reset
REQ-027 Asserting i_Rst_n=0 SHALL immediately set y=(P_HEIGHT-P_BALL_SIZE)/2, dir=1, spd=P_INIT_SPEED, line counter=0, o_Bounce=0 and the VBlank edge register=0.
REQ-028 Reset mid-frame SHALL discard all motion; the first update after reset SHALL occur on the first VBlank rising edge seen after release.

Configuration
REQ-029 The macro BALL_ACCEL_EN SHALL select acceleration.
REQ-030 With BALL_ACCEL_EN defined, each bounce SHALL increment spd by 1, saturating at 2^P_SPEED_BITS-1, applied together with the reflection; serve and reset SHALL restore the base speed.
REQ-031 Without BALL_ACCEL_EN, spd SHALL change only on serve and reset, and no accelerator logic SHALL be present.

Verification
REQ-032 Reset release, defaults: o_Y=236, o_Dir=1, o_Bounce=0; lines 236..243 give o_Video=1 and line 244 gives o_Video=0.
REQ-033 Serve with i_Speed=5 and i_ServeDir=1, then 3 frames: o_Y steps 236→241→246→251.
REQ-034 Bottom wall: o_Y=470, dir=1, spd=4, frame tick → o_Y=472, o_Dir=0, one o_Bounce pulse; next frame → o_Y=468.
REQ-035 Top wall: o_Y=3, dir=0, spd=3, frame tick → o_Y=0, o_Dir=1, o_Bounce pulses; i_Speed=0 serve then 4 frames → o_Y stays 236 with no bounce.
REQ-036 Serve on the same cycle as a frame tick → o_Y=236 with no motion; with BALL_ACCEL_EN: spd=7, bounce → spd stays 7; spd=2, bounce → spd=3.
